// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, NOP encoding, fetch FSM
// states and the IF/ID register payload.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;

  // sll $0,$0,0 -- the bubble word
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input  imem_rdata, imem_ready);
  modport slave  (input  imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register with hold (en=0) and synchronous bubble clear (clr=1).
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (en) q_d = clr ? '0 : d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem request FSM and IF/ID register.
// Define FETCH_DELAY_SLOT_EN to honour the branch delay slot on redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_d,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          instr_d,
  output logic [31:0]          pcplus4_d,
  output logic                 valid_d,
  output logic [5:0]           op_d,
  output logic [5:0]           funct_d
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc_plus4, redir_tgt;
  logic         req, fire, load;
  if_id_t       ifid_in, ifid_q;

`ifdef FETCH_DELAY_SLOT_EN
  logic         pend_q, pend_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
`endif

  assign pc_plus4  = pc_q + 32'd4;
  assign redir_tgt = redirect_pc & ~32'h3;
  assign fire      = req & imem.imem_ready & ~stall_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= BOOT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   state_d = imem.imem_ready ? FETCH : WAIT;
      WAIT:    state_d = imem.imem_ready ? FETCH : WAIT;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    req = (state_q != BOOT);
  end

  // PC sequencing; stall freezes everything, including a pending target
  always_comb begin
    pc_d = pc_q;
    load = 1'b0;
`ifdef FETCH_DELAY_SLOT_EN
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (!stall_d) begin
      if (fire) begin
        load   = 1'b1;
        pend_d = 1'b0;
        if (redirect)    pc_d = redir_tgt;
        else if (pend_q) pc_d = pend_pc_q;
        else             pc_d = pc_plus4;
      end else if (redirect) begin
        pend_d    = 1'b1;
        pend_pc_d = redir_tgt;
      end
    end
`else
    if (!stall_d) begin
      if (redirect) begin
        pc_d = redir_tgt;
      end else if (fire) begin
        load = 1'b1;
        pc_d = pc_plus4;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

`ifdef FETCH_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end
`endif

  assign ifid_in = '{instr: imem.imem_rdata, pcplus4: pc_plus4, valid: 1'b1};

  if_id_reg #(.W($bits(if_id_t))) u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (~stall_d),
    .clr     (~load),
    .d       (ifid_in),
    .q       (ifid_q)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr_d        = ifid_q.instr;
  assign pcplus4_d      = ifid_q.pcplus4;
  assign valid_d        = ifid_q.valid;
  assign op_d           = ifid_q.instr[31:26];
  assign funct_d        = ifid_q.instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns address-as-data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n, stall_d, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d, pcplus4_d, instr1_d, pcplus41_d;
  logic        valid_d, valid1_d;
  logic [5:0]  op_d, funct_d, op1_d, funct1_d;
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_stage_if m0 ();
  fetch_stage_if m1 ();

  assign m0.imem_rdata = m0.imem_addr;
  assign m1.imem_rdata = m1.imem_addr;
  assign m1.imem_ready = 1'b1;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .reset_n(reset_n), .stall_d(stall_d), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem(m0.master), .instr_d(instr_d),
    .pcplus4_d(pcplus4_d), .valid_d(valid_d), .op_d(op_d), .funct_d(funct_d)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset_n(reset_n), .stall_d(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem(m1.master), .instr_d(instr1_d),
    .pcplus4_d(pcplus41_d), .valid_d(valid1_d), .op_d(op1_d), .funct_d(funct1_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4,
                          input logic v);
    chk({tag, ".instr"},   instr_d,   ins);
    chk({tag, ".pcplus4"}, pcplus4_d, p4);
    chk({tag, ".valid"},   {31'b0, valid_d}, {31'b0, v});
  endtask

  // Reset, release, and run to pc=0xC with instr_d=8 in IF/ID
  task automatic run_to_c();
    reset_n = 1'b0; m0.imem_ready = 1'b1; stall_d = 1'b0; redirect = 1'b0;
    tick();
    chk("rst.addr", m0.imem_addr, 32'h0);
    chk("rst.req",  {31'b0, m0.imem_req}, 32'h0);
    chk("rst.valid", {31'b0, valid_d}, 32'h0);
    reset_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("to_c.addr", m0.imem_addr, 32'hC);
    chk("to_c.instr", instr_d, 32'h8);
  endtask

  initial begin
    reset_n = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    m0.imem_ready = 1'b1;

    // 1: startup
    tick(); tick();
    chk("reset.addr", m0.imem_addr, 32'h0);
    chk("reset.req",  {31'b0, m0.imem_req}, 32'h0);
    chk_ifid("reset", 32'h0, 32'h0, 1'b0);
    chk("reset.op",    {26'b0, op_d},    32'h0);
    chk("reset.funct", {26'b0, funct_d}, 32'h0);
    chk("wrap.reset_addr", m1.imem_addr, 32'hFFFF_FFFC);
    reset_n = 1'b1;
    chk("boot.req", {31'b0, m0.imem_req}, 32'h0);
    tick();
    chk("fetch0.req",  {31'b0, m0.imem_req}, 32'h1);
    chk("fetch0.addr", m0.imem_addr, 32'h0);
    chk("fetch0.valid", {31'b0, valid_d}, 32'h0);
    chk("wrap.addr1", m1.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("fetch4.addr", m0.imem_addr, 32'h4);
    chk_ifid("first", 32'h0, 32'h4, 1'b1);
    chk("wrap.addr2", m1.imem_addr, 32'h0);
    chk("wrap.pcplus4", pcplus41_d, 32'h0);
    tick();
    chk("fetch8.addr", m0.imem_addr, 32'h8);
    chk_ifid("second", 32'h4, 32'h8, 1'b1);

    // 2: memory wait at addr 8
    m0.imem_ready = 1'b0;
    tick();
    chk("wait1.addr", m0.imem_addr, 32'h8);
    chk("wait1.req",  {31'b0, m0.imem_req}, 32'h1);
    chk_ifid("wait1", 32'h0, 32'h0, 1'b0);
    tick();
    chk("wait2.addr", m0.imem_addr, 32'h8);
    chk("wait2.valid", {31'b0, valid_d}, 32'h0);
    m0.imem_ready = 1'b1;
    tick();
    chk_ifid("after_wait", 32'h8, 32'hC, 1'b1);
    tick();
    chk("pc10.addr", m0.imem_addr, 32'h10);

    // 3: stall at 0x10 with ignored redirect
    stall_d = 1'b1;
    tick();
    chk("stall1.addr", m0.imem_addr, 32'h10);
    chk_ifid("stall1", 32'hC, 32'h10, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("stall2.addr", m0.imem_addr, 32'h10);
    chk_ifid("stall2", 32'hC, 32'h10, 1'b1);
    redirect = 1'b0;
    tick();
    chk("stall3.addr", m0.imem_addr, 32'h10);
    stall_d = 1'b0;
    tick();
    chk("resume.addr", m0.imem_addr, 32'h14);
    chk_ifid("resume", 32'h10, 32'h14, 1'b1);

    // 4/5: redirect to 0x43 at pc 0xC (reset mid-operation first)
    run_to_c();
    redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    chk("redir.addr", m0.imem_addr, 32'h40);
`ifdef FETCH_DELAY_SLOT_EN
    chk_ifid("redir.slot", 32'hC, 32'h10, 1'b1);
`else
    chk_ifid("redir.bubble", 32'h0, 32'h0, 1'b0);
`endif
    tick();
    chk("redir.next", m0.imem_addr, 32'h44);
    chk_ifid("redir.target", 32'h40, 32'h44, 1'b1);
    chk("redir.op",    {26'b0, op_d},    32'h0);
    chk("redir.funct", {26'b0, funct_d}, 32'h0);

`ifdef FETCH_DELAY_SLOT_EN
    // 6: redirect while memory busy; delay slot completes first
    run_to_c();
    m0.imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h43;
    tick();
    redirect = 1'b0;
    chk("pend1.addr", m0.imem_addr, 32'hC);
    chk("pend1.valid", {31'b0, valid_d}, 32'h0);
    tick();
    chk("pend2.addr", m0.imem_addr, 32'hC);
    m0.imem_ready = 1'b1;
    tick();
    chk("pend.addr", m0.imem_addr, 32'h40);
    chk_ifid("pend.slot", 32'hC, 32'h10, 1'b1);
    tick();
    chk_ifid("pend.target", 32'h40, 32'h44, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the main decoder. It owns the PC register, drives the instruction-memory request, and holds the IF/ID pipeline register. It supplies `op_d`/`funct_d` straight to the decoder's `op`/`funct` inputs. It takes a stall from the hazard unit and a PC redirect (branch/j/jal/jr resolved in decode).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `stall_d  in  1`: hazard unit holds the PC and IF/ID.
- `redirect  in  1`: decode has resolved a taken branch, j, jal or jr.
- `redirect_pc  in  32`: target address for the redirect.
- `imem_req  out  1`: fetch request valid.
- `imem_addr  out  32`: fetch address; always equals the PC register.
- `imem_rdata  in  32`: instruction word; valid in any cycle where `imem_ready`=1.
- `imem_ready  in  1`: memory completes the request this cycle.
- `instr_d  out  32`: IF/ID instruction.
- `pcplus4_d  out  32`: IF/ID PC+4 (used for the jal link and branch base).
- `valid_d  out  1`: IF/ID holds a real instruction; 0 means bubble.
- `op_d  out  6`: `instr_d[31:26]`.
- `funct_d  out  6`: `instr_d[5:0]`.

## Operation
- **FSM states**
  - BOOT: first cycle after reset; `imem_req`=0; always moves to FETCH.
  - FETCH: `imem_req`=1; stays in FETCH.
  - WAIT: `imem_req`=1 while `imem_ready`=0; returns to FETCH on `imem_ready`.
- **Fetch completes** when `imem_req & imem_ready & !stall_d`.
  - IF/ID loads {`imem_rdata`, pc+4, valid=1}.
  - pc <= pc+4.
- **Memory not ready, no stall**: IF/ID loads a bubble (`instr_d`=0, i.e. sll nop; `valid_d`=0). The PC holds.
- **Stall** (`stall_d`=1):
  - PC and IF/ID hold.
  - Data returned in the same cycle is discarded; the same address is re-requested.
  - `redirect` is ignored while `stall_d`=1.
- **Redirect** (`redirect`=1, `stall_d`=0):
  - pc <= {redirect_pc[31:2], 2'b00}; low bits are silently cleared.
  - IF/ID is handled as described under Configuration.
- **Priority**: reset > stall > redirect > normal sequencing.
- **Arithmetic**: pc+4 is a 32-bit modulo add; 32'hFFFF_FFFC wraps to 0.
- `imem_ready` while `imem_req`=0 is ignored.

## Timing
- **Reset values**:
  - pc=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `imem_req`=0.
  - `instr_d`=0, `pcplus4_d`=0, `valid_d`=0, `op_d`=0, `funct_d`=0.
  - FSM=BOOT.
  - Redirect-pending flag clear.
- **Latency**: 1 cycle from a completed fetch to `instr_d`. Throughput is 1 instruction per cycle with zero-wait memory.
- **Redirect**: the target appears on `imem_addr` the cycle after `redirect`.
- **Reset mid-operation**: asserting reset abandons any outstanding request and any pending target. The stage then behaves exactly as at power-up.

## Configuration
- **`FETCH_DELAY_SLOT_EN` undefined**: on redirect, IF/ID loads a bubble. The wrong-path instruction fetched in that cycle is dropped.
- **`FETCH_DELAY_SLOT_EN` defined**: MIPS branch delay slot is honoured. The instruction fetched in the redirect cycle is loaded into IF/ID normally.
  - If `imem_ready`=0 in the redirect cycle, the target is latched in a pending register and pc is not redirected yet.
  - The delay-slot fetch completes at pc, then pc <= pending target and the pending flag clears.
  - A new `redirect` while the flag is set overwrites the pending target.

## Structure
- **Shared `mips_pkg`**:
  - opcode/funct constants.
  - `NOP_INSTR` (32'h0).
  - `fetch_state_t` enum {BOOT, FETCH, WAIT}.
- **Sub-module `if_id_reg`**:
  - Parameterised-width flop with enable (!stall) and synchronous clear (bubble).
  - Reused later for ID/EX.

## Test plan
1. **Startup**: reset_n low 2 cycles, then high, `imem_ready`=1, memory returns addr-as-data.
   - One BOOT cycle with `imem_req`=0.
   - `imem_addr` 0, 4, 8.
   - One cycle later `instr_d`=0 with `pcplus4_d`=4 and `valid_d`=1.
2. **Memory wait**: `imem_ready`=0 for 2 cycles at addr 8.
   - `imem_addr` holds 8; FSM in WAIT.
   - 2 bubbles with `valid_d`=0.
   - Then `instr_d`=8, `pcplus4_d`=12.
3. **Stall**: `stall_d`=1 for 3 cycles at pc 0x10, with `redirect`=1 in the middle cycle.
   - `instr_d`, `pcplus4_d` and pc are unchanged; the redirect is ignored.
   - Fetch resumes at 0x10.
4. **Redirect, macro undefined**: `redirect`=1, `redirect_pc`=0x43 while pc=0xC.
   - Next `imem_addr`=0x40.
   - IF/ID bubble.
   - Then `instr_d`=0x40.
5. **Redirect, macro defined, memory ready**: same stimulus as test 4.
   - IF/ID gets instruction 0xC as the delay slot.
   - Next `imem_addr`=0x40.
6. **Redirect, macro defined, memory busy and wrap**:
   - With `imem_ready`=0 in the redirect cycle, pc stays 0xC until its fetch completes, then goes to 0x40.
   - With `RESET_PC`=32'hFFFF_FFFC, the second `imem_addr` is 0.
